ram8_arbiter: RTL

//  Two-requester arbiter and sequencer in front of one RAM8 (8 x 16-bit register file).

---
 rtl/ram8_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ram8_arbiter.sv
`timescale 1ns/1ps
// ram8_arbiter: two-requester arbiter and sequencer in front of one RAM8
// (8 x 16-bit register file).
// Requests from ports A and B are serialised onto the single RAM8 port. Each
// accepted request returns one response through a single registered slot.
// A write returns the word's previous contents, so every access behaves as a swap.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   a_req_* / b_req_*       request handshake: valid/ready, we, addr, wdata
//   a_rsp_* / b_rsp_*       response handshake: valid/ready, rdata
//   ram_load/addr/in        RAM8 strobe, address and write data (same cycle as accept)
//   ram_out                 RAM8 read data, combinational on ram_addr
//   busy                    response slot occupied
module ram8_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req_valid,
    output logic        a_req_ready,
    input  logic        a_req_we,
    input  logic [2:0]  a_req_addr,
    input  logic [15:0] a_req_wdata,
    output logic        a_rsp_valid,
    input  logic        a_rsp_ready,
    output logic [15:0] a_rsp_rdata,
    input  logic        b_req_valid,
    output logic        b_req_ready,
    input  logic        b_req_we,
    input  logic [2:0]  b_req_addr,
    input  logic [15:0] b_req_wdata,
    output logic        b_rsp_valid,
    input  logic        b_rsp_ready,
    output logic [15:0] b_rsp_rdata,
    output logic        ram_load,
    output logic [2:0]  ram_addr,
    output logic [15:0] ram_in,
    input  logic [15:0] ram_out,
    output logic        busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;

    logic slot_free;
    logic grant_b;
    logic accept;

    // Slot state, response owner/data and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            owner_q <= PORT_A;
            data_q  <= '0;
            last_q  <= PORT_B;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Grant, RAM drive and next-state logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        data_d      = data_q;
        last_d      = last_q;
        ram_load    = 1'b0;
        ram_addr    = '0;
        ram_in      = '0;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;

        // Draining and accepting in the same cycle keeps one request per clock.
        slot_free = (state_q == S_EMPTY) | ((owner_q == PORT_B) ? b_rsp_ready : a_rsp_ready);

        // B wins when alone, or on a round-robin tie after A was last served.
        grant_b = b_req_valid & (~a_req_valid | ((PRIO_MODE == 0) & (last_q == PORT_A)));

        // rst_n gating keeps the combinational handshake quiet during reset.
        a_req_ready = rst_n & slot_free & a_req_valid & ~grant_b;
        b_req_ready = rst_n & slot_free & grant_b;
        accept      = a_req_ready | b_req_ready;

        if (accept) begin
            ram_load = grant_b ? b_req_we : a_req_we;
            ram_addr = grant_b ? b_req_addr : a_req_addr;
            ram_in   = grant_b ? b_req_wdata : a_req_wdata;
            state_d  = S_FULL;
            owner_d  = grant_b;
            // ram_out still shows the pre-write word at this edge.
            data_d   = ram_out;
            if (PRIO_MODE == 0) begin
                last_d = grant_b;
            end
        end else if ((state_q == S_FULL) && slot_free) begin
            state_d = S_EMPTY;
        end
    end

    assign busy        = (state_q == S_FULL);
    assign a_rsp_valid = (state_q == S_FULL) & (owner_q == PORT_A);
    assign b_rsp_valid = (state_q == S_FULL) & (owner_q == PORT_B);
    assign a_rsp_rdata = data_q;
    assign b_rsp_rdata = data_q;

    logic unused_aw;
    assign unused_aw = (AW == 3);

endmodule
